voice_allocator: RTL
====================

# voice_allocator

Converts the incoming MIDI byte stream into per-voice key events for the ADSR envelope block. It parses Note On/Off messages, maps each note onto one of NUM_VOICES voices through a sequentially scanned voice table, and drives the note-update interface that ADSR samples: flag, note status and voice index. Events are paced against the ADSR pipeline so that no update is dropped by the single-entry update buffer inside ADSR.

## Interface
- NUM_VOICES, 16, number of voices; 1..256.
- MIDI_CHANNEL, 0, 4-bit channel accepted; all other channels are ignored.

- i_clk  in  1  clock
- i_reset  in  1  reset; synchronous, active-high; clock i_clk
- i_byte_valid  in  1  one-cycle strobe; i_byte is valid
- i_byte  in  8  MIDI byte from the SPI/MIDI receiver
- i_pipeline_state  in  2  shared synth pipeline phase, the same signal ADSR sees
- o_note_flag  out  1  one-cycle update strobe; connects to ADSR i_SPI_flag
- o_note_status  out  1  1 = key down, 0 = key up; connects to ADSR i_SPI_note_status
- o_voice_index  out  8  target voice; connects to ADSR i_SPI_voice_index
- o_voice_note  out  7  MIDI note for o_voice_index; valid with o_note_flag, used by the oscillator increment table
- o_busy  out  1  high in every state except PARSE
- o_overrun  out  1  one-cycle pulse when a byte arrives while o_busy=1; that byte is dropped

## Operation
- Voice table, one entry per voice: active (1 bit), note (7 bits). Reset clears every entry.
- Parser, PARSE state only:
  - 0x8c or 0x9c, where c = MIDI_CHANNEL: latch as running status and expect 2 data bytes.
  - Any other byte in 0x80..0xF7: clear running status; following data bytes are ignored.
  - 0xF8..0xFF: ignored; running status is unaffected.
  - Data bytes (bit7 = 0) alternate note, then velocity. After the velocity byte, enter SCAN.
  - Note On with velocity 0 is treated as Note Off.
- SCAN: examine voice v = 0..NUM_VOICES-1, one voice per cycle. Record the first voice that is active with the same note (match) and the first inactive voice (free).
- After the scan, Note On:
  - match → on-event to the match voice (retrigger).
  - else free → on-event to the free voice.
  - else steal rule (see Configuration).
- After the scan, Note Off:
  - match → off-event and clear that entry's active bit.
  - no match → no event; return to PARSE.
- ISSUE, one cycle: drive o_note_flag=1 with o_note_status, o_voice_index and o_voice_note. The table entry (active, note) is written at the same clock edge.
- WAIT: hold until i_pipeline_state==2 is sampled, then go to PARSE on the next cycle. This guarantees ADSR has cleared its buffer before the next flag.
- FSM path: PARSE → SCAN → (ISSUE → WAIT →) PARSE.

## Timing
- Reset values: o_note_flag=0, o_note_status=0, o_voice_index=0, o_voice_note=0, o_busy=0, o_overrun=0. FSM=PARSE, running status cleared, steal pointer=0.
- Reset mid-scan or mid-wait abandons the event, and no flag is issued.
- Velocity byte accepted at edge E: SCAN occupies cycles E+1..E+NUM_VOICES. o_note_flag is high during cycle E+NUM_VOICES+1.
- o_voice_index, o_voice_note and o_note_status hold their values after the flag until the next ISSUE.
- o_note_flag is never high on two cycles without an intervening sampled i_pipeline_state==2.
- If i_pipeline_state==2 in the cycle directly after ISSUE, that sample counts, and WAIT lasts 1 cycle.
- o_overrun and the dropping of a byte happen in the same cycle the byte arrives.

## Configuration
- VOICE_STEAL_EN defined: a Note On with no match and no free voice steals the voice at the steal pointer. The block issues an on-event to that voice, overwrites its note, and increments the steal pointer modulo NUM_VOICES.
- VOICE_STEAL_EN undefined: that Note On is discarded with no flag. The steal pointer logic is not built.

## Test plan
- Bytes 0x90,0x3C,0x64 → after 17 cycles (NUM_VOICES=16), one flag: status=1, voice=0, note=0x3C. Then 0x80,0x3C,0x00 → flag: status=0, voice=0; entry 0 inactive.
- Running status: 0x90,0x3C,0x64,0x40,0x64 → voice 0 gets note 0x3C, voice 1 gets note 0x40. Then 0x40,0x00 → off-event to voice 1.
- Hold i_pipeline_state≠2 for 50 cycles after ISSUE, then send a new byte → o_overrun pulses and the byte is dropped. The next flag appears only after state 2 is sampled.
- Fill 16 voices with notes 0x30..0x3F, then Note On 0x50. With VOICE_STEAL_EN: flag to voice 0 with note 0x50, and the next steal goes to voice 1. Without it: no flag.
- Wrong channel 0x91,0x3C,0x64 → no flag. Interleaved 0xF8 inside a message → message completes normally. Note Off for an unmapped note → no flag.
- Assert i_reset during SCAN → no flag, outputs zero; a fresh Note On then targets voice 0.

Source files
------------

// File: rtl/voice_allocator_if.sv
// Note-update bus between the MIDI byte source, the voice allocator and ADSR.
// Signal names are written from the allocator's point of view.
interface voice_allocator_if;
  logic       i_byte_valid;
  logic [7:0] i_byte;
  logic       o_note_flag;
  logic       o_note_status;
  logic [7:0] o_voice_index;
  logic [6:0] o_voice_note;

  // Byte source / note consumer side
  modport master (
    output i_byte_valid, i_byte,
    input  o_note_flag, o_note_status, o_voice_index, o_voice_note
  );

  // Voice allocator side
  modport slave (
    input  i_byte_valid, i_byte,
    output o_note_flag, o_note_status, o_voice_index, o_voice_note
  );
endinterface

// File: rtl/voice_allocator.sv
// MIDI Note On/Off parser and voice allocator feeding the ADSR note-update port.
// Optional feature: define VOICE_STEAL_EN to steal a voice (round-robin pointer)
// when a Note On finds neither a matching nor a free voice.
module voice_allocator #(
  parameter int unsigned NUM_VOICES   = 16,
  parameter logic [3:0]  MIDI_CHANNEL = 4'd0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  voice_allocator_if.slave   bus,
  input  logic [1:0]         i_pipeline_state,
  output logic               o_busy,
  output logic               o_overrun
);

  localparam int unsigned    IW   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IW-1:0]  LAST = IW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {S_PARSE, S_SCAN, S_ISSUE, S_WAIT} state_t;

  state_t r_state, w_next;

  // Parser state
  logic          r_rs_valid, r_rs_on, r_have_note, r_is_on;
  logic [6:0]    r_note;

  // Voice table
  logic [NUM_VOICES-1:0] r_active;
  logic [6:0]            r_note_tab [NUM_VOICES];

  // Scan bookkeeping
  logic [IW-1:0] r_scan_idx, r_match_idx, r_free_idx, r_tgt;
  logic          r_match_vld, r_free_vld;

  logic          w_take, w_vel_done, w_last;
  logic          w_cur_match, w_cur_free, w_any_match, w_any_free, w_go_issue;
  logic [IW-1:0] w_match_idx, w_free_idx, w_tgt;

`ifdef VOICE_STEAL_EN
  logic [IW-1:0] r_steal_ptr;
  logic          r_tgt_steal, w_steal;
`endif

  assign w_take     = bus.i_byte_valid && (r_state == S_PARSE);
  assign w_vel_done = w_take && !bus.i_byte[7] && r_rs_valid && r_have_note;
  assign w_last     = (r_scan_idx == LAST);

  // Match/free result including the voice examined this cycle
  always_comb begin
    w_cur_match = r_active[r_scan_idx] && (r_note_tab[r_scan_idx] == r_note);
    w_cur_free  = !r_active[r_scan_idx];
    w_any_match = r_match_vld || w_cur_match;
    w_match_idx = r_match_vld ? r_match_idx : r_scan_idx;
    w_any_free  = r_free_vld || w_cur_free;
    w_free_idx  = r_free_vld ? r_free_idx : r_scan_idx;
  end

  // End-of-scan decision: retrigger/off on match, else free voice, else steal
  always_comb begin
    w_go_issue = 1'b0;
    w_tgt      = w_match_idx;
`ifdef VOICE_STEAL_EN
    w_steal    = 1'b0;
`endif
    if (w_any_match) begin
      w_go_issue = 1'b1;
    end else if (r_is_on) begin
      if (w_any_free) begin
        w_go_issue = 1'b1;
        w_tgt      = w_free_idx;
      end else begin
`ifdef VOICE_STEAL_EN
        w_go_issue = 1'b1;
        w_tgt      = r_steal_ptr;
        w_steal    = 1'b1;
`endif
      end
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_PARSE;
    else         r_state <= w_next;
  end

  // FSM next state and strobe outputs
  always_comb begin
    w_next          = r_state;
    bus.o_note_flag = 1'b0;
    o_busy          = (r_state != S_PARSE);
    o_overrun       = bus.i_byte_valid && (r_state != S_PARSE) && !i_reset;
    unique case (r_state)
      S_PARSE: if (w_vel_done) w_next = S_SCAN;
      S_SCAN:  if (w_last) w_next = w_go_issue ? S_ISSUE : S_PARSE;
      S_ISSUE: begin
        bus.o_note_flag = 1'b1;
        w_next          = S_WAIT;
      end
      S_WAIT:  if (i_pipeline_state == 2'd2) w_next = S_PARSE;
      default: w_next = S_PARSE;
    endcase
  end

  // MIDI parser: running status, note/velocity alternation
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rs_valid  <= 1'b0;
      r_rs_on     <= 1'b0;
      r_have_note <= 1'b0;
      r_is_on     <= 1'b0;
      r_note      <= '0;
    end else if (w_take) begin
      if (bus.i_byte[7]) begin
        if (bus.i_byte < 8'hF8) begin
          r_rs_valid  <= (bus.i_byte[3:0] == MIDI_CHANNEL) &&
                         (bus.i_byte[7:4] == 4'h8 || bus.i_byte[7:4] == 4'h9);
          r_rs_on     <= bus.i_byte[4];
          r_have_note <= 1'b0;
        end
      end else if (r_rs_valid) begin
        if (!r_have_note) begin
          r_note      <= bus.i_byte[6:0];
          r_have_note <= 1'b1;
        end else begin
          r_have_note <= 1'b0;
          r_is_on     <= r_rs_on && (bus.i_byte[6:0] != 7'd0);
        end
      end
    end
  end

  // Sequential voice scan and latching of the issued event
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scan_idx        <= '0;
      r_match_vld       <= 1'b0;
      r_match_idx       <= '0;
      r_free_vld        <= 1'b0;
      r_free_idx        <= '0;
      r_tgt             <= '0;
      bus.o_note_status <= 1'b0;
      bus.o_voice_index <= '0;
      bus.o_voice_note  <= '0;
`ifdef VOICE_STEAL_EN
      r_tgt_steal       <= 1'b0;
`endif
    end else if (r_state == S_SCAN) begin
      r_scan_idx <= r_scan_idx + 1'b1;
      if (w_cur_match && !r_match_vld) begin
        r_match_vld <= 1'b1;
        r_match_idx <= r_scan_idx;
      end
      if (w_cur_free && !r_free_vld) begin
        r_free_vld <= 1'b1;
        r_free_idx <= r_scan_idx;
      end
      if (w_last && w_go_issue) begin
        r_tgt             <= w_tgt;
        bus.o_note_status <= r_is_on;
        bus.o_voice_index <= 8'(w_tgt);
        bus.o_voice_note  <= r_note;
`ifdef VOICE_STEAL_EN
        r_tgt_steal       <= w_steal;
`endif
      end
    end else if (r_state == S_PARSE) begin
      r_scan_idx  <= '0;
      r_match_vld <= 1'b0;
      r_free_vld  <= 1'b0;
    end
  end

  // Voice table update, written on the ISSUE edge
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_active <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) r_note_tab[i] <= '0;
    end else if (r_state == S_ISSUE) begin
      r_active[r_tgt]   <= r_is_on;
      r_note_tab[r_tgt] <= r_note;
    end
  end

`ifdef VOICE_STEAL_EN
  // Round-robin steal pointer, advanced only by an issued steal
  always_ff @(posedge i_clk) begin
    if (i_reset) r_steal_ptr <= '0;
    else if (r_state == S_ISSUE && r_tgt_steal)
      r_steal_ptr <= (r_steal_ptr == LAST) ? '0 : r_steal_ptr + 1'b1;
  end
`endif

endmodule
